// File: rtl/sample_mul_share_arb.sv
// Round-robin arbiter sharing one 2-stage pipelined signed multiplier among NUM_REQ requesters.
// Each product is returned tagged with the ID of the requester that issued it.
module sample_mul_share_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int DATA_W  = 11
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ce,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [ID_W-1:0]           res_id,
    output logic [DATA_W-1:0]         res_p,
    output logic                      busy
);

    logic [ID_W-1:0]          rr_ptr_q, rr_ptr_d;
    logic                     s1_valid_q, s1_valid_d;
    logic [ID_W-1:0]          s1_id_q, s1_id_d;
    logic signed [DATA_W-1:0] s1_a_q, s1_a_d;
    logic signed [DATA_W-1:0] s1_b_q, s1_b_d;
    logic                     s2_valid_q, s2_valid_d;
    logic [ID_W-1:0]          s2_id_q, s2_id_d;
    logic [DATA_W-1:0]        s2_p_q, s2_p_d;

    logic                       adv;
    logic                       grant_found;
    logic                       transfer;
    logic [ID_W-1:0]            grant_id;
    logic signed [2*DATA_W-1:0] prod_full;

    // Holding off grants while reset is high keeps a handshake from being acknowledged and then dropped.
    assign adv      = ce & ~reset & ~(s2_valid_q & ~res_ready);
    assign transfer = adv & grant_found;

    // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin : arbiter
        int               idx;
        logic [ID_W-1:0]  idx_id;
        idx         = 0;
        idx_id      = '0;
        grant_found = 1'b0;
        grant_id    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            idx_id = ID_W'(idx);
            if (!grant_found && req_valid[idx_id]) begin
                grant_found = 1'b1;
                grant_id    = idx_id;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (transfer) req_ready[grant_id] = 1'b1;
    end

    always_comb begin
        prod_full  = (2*DATA_W)'(s1_a_q) * (2*DATA_W)'(s1_b_q);
        rr_ptr_d   = rr_ptr_q;
        s1_valid_d = s1_valid_q;
        s1_id_d    = s1_id_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s2_valid_d = s2_valid_q;
        s2_id_d    = s2_id_q;
        s2_p_d     = s2_p_q;
        if (transfer) begin
            rr_ptr_d = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        end
        if (adv) begin
            s1_valid_d = transfer;
            s1_id_d    = grant_id;
            s1_a_d     = req_a[int'(grant_id)*DATA_W +: DATA_W];
            s1_b_d     = req_b[int'(grant_id)*DATA_W +: DATA_W];
            s2_valid_d = s1_valid_q;
            s2_id_d    = s1_id_q;
            s2_p_d     = prod_full[DATA_W-1:0];
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q   <= '0;
            s1_valid_q <= 1'b0;
            s1_id_q    <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_id_q    <= '0;
            s2_p_q     <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            s1_valid_q <= s1_valid_d;
            s1_id_q    <= s1_id_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s2_valid_q <= s2_valid_d;
            s2_id_q    <= s2_id_d;
            s2_p_q     <= s2_p_d;
        end
    end

    assign res_valid = s2_valid_q;
    assign res_id    = s2_id_q;
    assign res_p     = s2_p_q;
    assign busy      = s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_sample_mul_share_arb.sv
// Scoreboard bench for sample_mul_share_arb: directed operand vectors with hand-computed
// grants and products; a negedge monitor pops expected results as the DUT emits them.
module tb_sample_mul_share_arb;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int DATA_W  = 11;

    typedef struct {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] p;
    } exp_t;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      ce;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic                      res_valid;
    logic                      res_ready;
    logic [ID_W-1:0]           res_id;
    logic [DATA_W-1:0]         res_p;
    logic                      busy;

    exp_t              sb[$];
    logic [DATA_W-1:0] exp_p[NUM_REQ];
    int                n_cmp  = 0;
    int                n_fail = 0;

    sample_mul_share_arb #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .ce(ce),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_id(res_id), .res_p(res_p), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input int a, input int b, input int p);
        req_a[i*DATA_W +: DATA_W] = 11'(a);
        req_b[i*DATA_W +: DATA_W] = 11'(b);
        exp_p[i]                  = 11'(p);
        req_valid[i]              = 1'b1;
    endtask

    task automatic clr_req(input int i);
        req_valid[i] = 1'b0;
    endtask

    // Called one time unit after a rising edge; checks the expected grant, records the
    // expected product for it, and returns one time unit after the next rising edge.
    task automatic cycle(input logic [NUM_REQ-1:0] exp_ready, input bit push);
        #1;
        check("req_ready", req_ready, exp_ready);
        if (push) begin
            for (int i = 0; i < NUM_REQ; i++)
                if (exp_ready[i]) sb.push_back('{id: ID_W'(i), p: exp_p[i]});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle('0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (!reset && ce && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 32'(res_id), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("res_id", 32'(res_id), 32'(e.id));
                check("res_p", 32'(res_p), 32'(e.p));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        ce        = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) exp_p[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("rst_res_valid", 32'(res_valid), 0);
        check("rst_res_id", 32'(res_id), 0);
        check("rst_res_p", 32'(res_p), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_req_ready", 32'(req_ready), 0);

        // Single request from requester 2: 5 * -3 = -15, two-cycle latency.
        set_req(2, 5, -3, -15);
        cycle(4'b0100, 1'b1);
        check("lat1_res_valid", 32'(res_valid), 0);
        check("lat1_busy", 32'(busy), 1);
        clr_req(2);
        cycle(4'b0000, 1'b0);
        check("lat2_res_valid", 32'(res_valid), 1);
        drain(2);

        // Pointer sits at 3 after granting 2, so 3 wins over 0, then 0, then 3 again.
        set_req(0, 7, 8, 56);
        set_req(3, -2, 9, -18);
        cycle(4'b1000, 1'b1);
        cycle(4'b0001, 1'b1);
        clr_req(0);
        cycle(4'b1000, 1'b1);
        clr_req(3);
        drain(3);

        // All four contend continuously: grants rotate 0,1,2,3,0.
        set_req(0, 3, 4, 12);
        set_req(1, -5, 6, -30);
        set_req(2, 100, -7, -700);
        set_req(3, -11, -11, 121);
        cycle(4'b0001, 1'b1);
        cycle(4'b0010, 1'b1);
        cycle(4'b0100, 1'b1);
        cycle(4'b1000, 1'b1);
        cycle(4'b0001, 1'b1);
        req_valid = '0;
        drain(3);

        // Wrap-around products: 2046 -> 0x7FE, 1024 -> -1024, 2^20 -> 0.
        set_req(1, 1023, 2, 'h7FE);
        cycle(4'b0010, 1'b1);
        set_req(1, -1024, -1, -1024);
        cycle(4'b0010, 1'b1);
        set_req(1, -1024, -1024, 0);
        cycle(4'b0010, 1'b1);
        clr_req(1);
        drain(3);

        // Backpressure while requester 1 streams.
        set_req(1, 2, 3, 6);
        cycle(4'b0010, 1'b1);
        set_req(1, -4, 5, -20);
        cycle(4'b0010, 1'b1);
        set_req(1, 10, 10, 100);
        cycle(4'b0010, 1'b1);
        res_ready = 1'b0;
        set_req(1, -7, -7, 49);
        for (int i = 0; i < 3; i++) begin
            check("stall_res_valid", 32'(res_valid), 1);
            check("stall_res_id", 32'(res_id), 1);
            check("stall_res_p", 32'(res_p), 32'(11'h7EC));
            cycle(4'b0000, 1'b0);
        end
        check("stall_end_res_p", 32'(res_p), 32'(11'h7EC));
        res_ready = 1'b1;
        cycle(4'b0010, 1'b1);
        clr_req(1);
        drain(3);

        // Clock-enable gap with two items in flight.
        set_req(2, 12, -12, -144);
        cycle(4'b0100, 1'b1);
        clr_req(2);
        set_req(3, 31, 33, 1023);
        cycle(4'b1000, 1'b1);
        ce = 1'b0;
        clr_req(3);
        set_req(0, 1, 1, 1);
        for (int i = 0; i < 4; i++) begin
            check("ce_res_valid", 32'(res_valid), 1);
            check("ce_res_id", 32'(res_id), 2);
            check("ce_res_p", 32'(res_p), 32'(11'h770));
            check("ce_busy", 32'(busy), 1);
            cycle(4'b0000, 1'b0);
        end
        ce = 1'b1;
        cycle(4'b0001, 1'b1);
        clr_req(0);
        drain(3);

        // Reset with both stages occupied; those products must never appear.
        set_req(1, 3, 3, 9);
        cycle(4'b0010, 1'b0);
        clr_req(1);
        set_req(2, 4, 4, 16);
        cycle(4'b0100, 1'b0);
        reset = 1'b1;
        clr_req(2);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("mid_rst_res_valid", 32'(res_valid), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_res_p", 32'(res_p), 0);
        check("mid_rst_req_ready", 32'(req_ready), 0);
        set_req(1, 5, 5, 25);
        set_req(0, -3, -3, 9);
        cycle(4'b0001, 1'b1);
        req_valid = '0;
        drain(4);
        check("scoreboard_empty", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sample_mul_share_arb.md
Name: sample_mul_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one pipelined signed 11x11 multiplier among NUM_REQ requesters.
- Each requester offers an operand pair over a valid/ready handshake.
- The block grants one pair per cycle and pushes it through an internal 2-stage multiply pipeline.
- Each product is returned with the ID of the requester that issued it; used where several loop bodies contend for a single DSP multiply slot.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester ID; equals ceil(log2(NUM_REQ)).
- DATA_W, 11, operand and product width (signed).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- ce  in  1  global clock enable; 0 freezes all state.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero).
- req_a  in  NUM_REQ*DATA_W  packed operand A; slice i belongs to requester i.
- req_b  in  NUM_REQ*DATA_W  packed operand B; slice i belongs to requester i.
- res_valid  out  1  product valid.
- res_ready  in  1  consumer accepts product.
- res_id  out  ID_W  requester that issued the product.
- res_p  out  DATA_W  signed product, low DATA_W bits.
- busy  out  1  any pipeline stage holds a valid entry.

Behaviour:
- Reset: synchronous, active-high; wins over ce.
  - Clears s1_valid and s2_valid; sets rr_ptr to 0.
  - res_valid=0, res_id=0, res_p=0, busy=0, req_ready=0 in the cycle after reset is sampled.
  - Reset mid-operation discards in-flight products; none are emitted afterward.
- Stall: stall = res_valid & ~res_ready. Define adv = ce & ~stall.
- Arbitration (combinational):
  - When adv=1 and any req_valid is set, grant g = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_ready[g]=1; all other req_ready bits are 0.
  - When adv=0, req_ready is all 0.
  - req_ready never depends on req_a or req_b.
  - A transfer occurs when req_valid[i] & req_ready[i] are both 1.
- Pointer: on a transfer, rr_ptr <= (g+1) mod NUM_REQ. With no transfer, rr_ptr holds. This guarantees no requester waits more than NUM_REQ-1 grants.
- Pipeline: two stages, both advancing only when adv=1.
  - Stage 1: s1_valid <= transfer; s1_id <= g; s1_a/s1_b <= slices g of req_a/req_b. Operands are registered; product is not yet formed.
  - Stage 2: s2_valid <= s1_valid; s2_id <= s1_id; s2_p <= low DATA_W bits of signed(s1_a)*signed(s1_b). Overflow wraps (two's-complement truncation, no saturation).
  - Outputs: res_valid=s2_valid, res_id=s2_id, res_p=s2_p.
- Latency: transfer at edge N gives res_valid=1 after edge N+2 (2 cycles) when there are no stalls. Throughput is 1 product per cycle.
- Stall and ce=0: all stage registers and rr_ptr hold. res_* stay stable while res_valid=1 and res_ready=0. A product leaves only on res_valid & res_ready.
- Bubbles: when adv=1 and stage 2 is empty or draining, bubbles (valid=0) advance normally. Payload regs of invalid stages may hold stale data, but res_valid=0 then.
- busy = s1_valid | s2_valid.
- Simultaneous events:
  - res_ready rising in the same cycle as a new request: adv=1, so the request is accepted and the pipeline shifts.
  - req_valid dropping without a transfer is allowed; no state change.
  - NUM_REQ not a power of two: the pointer wraps from NUM_REQ-1 to 0, never to an unused index.

Test Plan:
- Reset, then one request: req 2 valid, a=5, b=-3, res_ready=1 -> req_ready=0100 at once; 2 cycles later res_valid=1, res_id=2, res_p=-15; rr_ptr=3.
- All four valid continuously, res_ready=1 -> grants cycle 0,1,2,3,0; results arrive back-to-back, in the same ID order, 2 cycles behind.
- Overflow: a=1023, b=2 (-> 2046) -> res_p=0x7FE (11-bit wrap, reads -2); a=-1024, b=-1 -> res_p=-1024.
- Backpressure: stream from req 1, drop res_ready for 3 cycles while res_valid=1 -> res_p/res_id frozen, req_ready=0, no loss or duplication; release -> remaining results resume in order.
- ce=0 for 4 cycles with 2 items in flight -> all outputs and req_ready frozen/0; ce=1 -> items appear as if no gap.
- Reset asserted with s1 and s2 both valid -> next cycle res_valid=0, busy=0, rr_ptr=0; no stale product later.
